// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: block and rotation codes, colours and the cell offset table.
package tetris_pkg;

  typedef enum logic [2:0] {
    BLK_J   = 3'd0,
    BLK_L   = 3'd1,
    BLK_S   = 3'd2,
    BLK_T   = 3'd3,
    BLK_Z   = 3'd4,
    BLK_I   = 3'd5,
    BLK_O   = 3'd6,
    BLK_BAD = 3'd7
  } block_e;

  typedef enum logic [1:0] {
    ST_0 = 2'd0,
    ST_R = 2'd1,
    ST_2 = 2'd2,
    ST_L = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StRead,
    StDrain,
    StResp
  } probe_state_t;

  localparam int unsigned NUM_BLOCKS = 7;
  localparam int unsigned NUM_CELLS  = 4;

  localparam logic [11:0] COLOR_J = 12'h22f;
  localparam logic [11:0] COLOR_L = 12'hf80;
  localparam logic [11:0] COLOR_S = 12'h0f0;
  localparam logic [11:0] COLOR_T = 12'hd7d;
  localparam logic [11:0] COLOR_Z = 12'hf00;
  localparam logic [11:0] COLOR_I = 12'h0ff;
  localparam logic [11:0] COLOR_O = 12'hff0;

  // Offsets in -2..+2; dy grows towards higher row indices.
  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } cell_off_t;

  function automatic cell_off_t mk_off(input int dx, input int dy);
    cell_off_t o;
    o.dx = 3'(dx);
    o.dy = 3'(dy);
    return o;
  endfunction

  // [block][status][cell]; cell 0 is always the pivot. Each status is the previous one
  // rotated a quarter turn clockwise about the pivot; O does not rotate.
  localparam cell_off_t PIECE_OFFSETS [NUM_BLOCKS][4][NUM_CELLS] = '{
    // J
    '{'{mk_off(0, 0), mk_off(-1,  1), mk_off(-1,  0), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 1,  1), mk_off( 0,  1), mk_off( 0, -1)},
      '{mk_off(0, 0), mk_off( 1, -1), mk_off( 1,  0), mk_off(-1,  0)},
      '{mk_off(0, 0), mk_off(-1, -1), mk_off( 0, -1), mk_off( 0,  1)}},
    // L
    '{'{mk_off(0, 0), mk_off( 1,  1), mk_off(-1,  0), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 1, -1), mk_off( 0,  1), mk_off( 0, -1)},
      '{mk_off(0, 0), mk_off(-1, -1), mk_off( 1,  0), mk_off(-1,  0)},
      '{mk_off(0, 0), mk_off(-1,  1), mk_off( 0, -1), mk_off( 0,  1)}},
    // S
    '{'{mk_off(0, 0), mk_off(-1,  0), mk_off( 0,  1), mk_off( 1,  1)},
      '{mk_off(0, 0), mk_off( 0,  1), mk_off( 1,  0), mk_off( 1, -1)},
      '{mk_off(0, 0), mk_off( 1,  0), mk_off( 0, -1), mk_off(-1, -1)},
      '{mk_off(0, 0), mk_off( 0, -1), mk_off(-1,  0), mk_off(-1,  1)}},
    // T
    '{'{mk_off(0, 0), mk_off( 0,  1), mk_off(-1,  0), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 1,  0), mk_off( 0,  1), mk_off( 0, -1)},
      '{mk_off(0, 0), mk_off( 0, -1), mk_off( 1,  0), mk_off(-1,  0)},
      '{mk_off(0, 0), mk_off(-1,  0), mk_off( 0, -1), mk_off( 0,  1)}},
    // Z
    '{'{mk_off(0, 0), mk_off(-1,  1), mk_off( 0,  1), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 1,  1), mk_off( 1,  0), mk_off( 0, -1)},
      '{mk_off(0, 0), mk_off( 1, -1), mk_off( 0, -1), mk_off(-1,  0)},
      '{mk_off(0, 0), mk_off(-1, -1), mk_off(-1,  0), mk_off( 0,  1)}},
    // I
    '{'{mk_off(0, 0), mk_off(-1,  0), mk_off( 1,  0), mk_off( 2,  0)},
      '{mk_off(0, 0), mk_off( 0,  1), mk_off( 0, -1), mk_off( 0, -2)},
      '{mk_off(0, 0), mk_off( 1,  0), mk_off(-1,  0), mk_off(-2,  0)},
      '{mk_off(0, 0), mk_off( 0, -1), mk_off( 0,  1), mk_off( 0,  2)}},
    // O
    '{'{mk_off(0, 0), mk_off( 0,  1), mk_off( 1,  1), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 0,  1), mk_off( 1,  1), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 0,  1), mk_off( 1,  1), mk_off( 1,  0)},
      '{mk_off(0, 0), mk_off( 0,  1), mk_off( 1,  1), mk_off( 1,  0)}}
  };

  // Colour for a block code; the illegal code maps to black.
  function automatic logic [11:0] block_color(input logic [2:0] block);
    logic [11:0] c;
    case (block)
      BLK_J:   c = COLOR_J;
      BLK_L:   c = COLOR_L;
      BLK_S:   c = COLOR_S;
      BLK_T:   c = COLOR_T;
      BLK_Z:   c = COLOR_Z;
      BLK_I:   c = COLOR_I;
      BLK_O:   c = COLOR_O;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/piece_offsets.sv
// Combinational lookup of the four cell offsets of a piece; shared with the renderer.
module piece_offsets
  import tetris_pkg::*;
(
  input  logic [2:0] block,
  input  logic [1:0] status,
  output cell_off_t  cells [NUM_CELLS],
  output logic       legal
);

  // Illegal codes yield all-zero offsets so downstream index math stays benign.
  always_comb begin
    legal = (block != BLK_BAD);
    for (int i = 0; i < NUM_CELLS; i++) begin
      cells[i] = legal ? PIECE_OFFSETS[block][status][i] : '0;
    end
  end

endmodule

// File: rtl/piece_probe.sv
// Sequential placement checker: derives the four cells of a piece, bounds-checks them and
// reads board occupancy one cell per cycle before presenting a held response.
module piece_probe
  import tetris_pkg::*;
#(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 20,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned IDX_W   = $clog2(BOARD_W * BOARD_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_block,
  input  logic [1:0]         req_status,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               occ_rd_en,
  output logic [IDX_W-1:0]   occ_rd_addr,
  input  logic               occ_rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic               rsp_oob,
  output logic [11:0]        rsp_color,
  output logic [IDX_W-1:0]   rsp_pos0,
  output logic [IDX_W-1:0]   rsp_pos1,
  output logic [IDX_W-1:0]   rsp_pos2,
  output logic [IDX_W-1:0]   rsp_pos3
);

  // Two guard bits so pivot + offset can go negative or past the board edge without wrapping.
  localparam int unsigned CW = COORD_W + 2;

  probe_state_t       state_q, state_d;
  logic [2:0]         block_q, block_d;
  logic [1:0]         status_q, status_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [1:0]         k_q, k_d;
  logic               hit_q, hit_d;
  logic               oob_q, oob_d;
  logic [11:0]        color_q, color_d;
  logic [IDX_W-1:0]   pos_q [NUM_CELLS];
  logic [IDX_W-1:0]   pos_d [NUM_CELLS];

  cell_off_t          offs [NUM_CELLS];
  logic               legal;
  logic [CW-1:0]      cx [NUM_CELLS];
  logic [CW-1:0]      cy [NUM_CELLS];
  logic [NUM_CELLS-1:0] cell_oob;
  logic [IDX_W-1:0]   cell_idx [NUM_CELLS];
  logic               piece_oob;

  piece_offsets u_offsets (
    .block  (block_q),
    .status (status_q),
    .cells  (offs),
    .legal  (legal)
  );

  // Absolute coordinates, per-cell bounds and linear indices of the captured request.
  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      cx[i] = {2'b00, x_q} + {{(CW - 3){offs[i].dx[2]}}, offs[i].dx};
      cy[i] = {2'b00, y_q} + {{(CW - 3){offs[i].dy[2]}}, offs[i].dy};
      // A negative result has its MSB set; the explicit test keeps intent readable.
      cell_oob[i] = cx[i][CW-1] || (cx[i] >= CW'(BOARD_W)) ||
                    cy[i][CW-1] || (cy[i] >= CW'(BOARD_H));
      cell_idx[i] = IDX_W'(32'(cy[i]) * BOARD_W + 32'(cx[i]));
    end
    piece_oob = !legal || (|cell_oob);
  end

  // Next-state logic: capture, evaluate, sequence four reads, then hold the response.
  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    status_d = status_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    hit_d    = hit_q;
    oob_d    = oob_q;
    color_d  = color_q;
    pos_d    = pos_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          block_d  = req_block;
          status_d = req_status;
          x_d      = req_x;
          y_d      = req_y;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        oob_d   = piece_oob;
        hit_d   = 1'b0;
        color_d = block_color(block_q);
        for (int i = 0; i < NUM_CELLS; i++) begin
          pos_d[i] = legal ? cell_idx[i] : '0;
        end
        k_d     = 2'd0;
        state_d = piece_oob ? StResp : StRead;
      end
      StRead: begin
        // Data lags the strobe by one cycle, so the first read cycle has nothing to sample.
        if (k_q != 2'd0) begin
          hit_d = hit_q | occ_rd_data;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        hit_d   = hit_q | occ_rd_data;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      block_q  <= '0;
      status_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      hit_q    <= 1'b0;
      oob_q    <= 1'b0;
      color_q  <= '0;
      pos_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      status_q <= status_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      hit_q    <= hit_d;
      oob_q    <= oob_d;
      color_q  <= color_d;
      pos_q    <= pos_d;
    end
  end

  // All outputs decode registered state only.
  always_comb begin
    req_ready   = (state_q == StIdle);
    occ_rd_en   = (state_q == StRead);
    occ_rd_addr = occ_rd_en ? pos_q[k_q] : '0;
    rsp_valid   = (state_q == StResp);
    rsp_hit     = hit_q;
    rsp_oob     = oob_q;
    rsp_color   = color_q;
    rsp_pos0    = pos_q[0];
    rsp_pos1    = pos_q[1];
    rsp_pos2    = pos_q[2];
    rsp_pos3    = pos_q[3];
  end

endmodule

// File: tb/tb_piece_probe.sv
// Scoreboard bench for piece_probe: directed requests push expected responses, monitors
// pop and compare whenever a probe presents a response.
module tb_piece_probe;

  typedef struct packed {
    logic            hit;
    logic            oob;
    logic [11:0]     color;
    logic [3:0][7:0] pos;
    logic [3:0]      pmask;
    logic [7:0]      lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid, req_valid12;
  logic [2:0] req_block;
  logic [1:0] req_status;
  logic [4:0] req_x, req_y;
  logic       rsp_ready, rsp_ready12;
  logic       occ_rd_data, occ_rd_data12;

  logic       req_ready, occ_rd_en, rsp_valid, rsp_hit, rsp_oob;
  logic [7:0] occ_rd_addr, rsp_pos0, rsp_pos1, rsp_pos2, rsp_pos3;
  logic [11:0] rsp_color;
  logic       req_ready12, occ_rd_en12, rsp_valid12, rsp_hit12, rsp_oob12;
  logic [7:0] occ_rd_addr12, rsp_pos0_12, rsp_pos1_12, rsp_pos2_12, rsp_pos3_12;
  logic [11:0] rsp_color12;

  piece_probe dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_block (req_block),
    .req_status (req_status), .req_x (req_x), .req_y (req_y),
    .occ_rd_en (occ_rd_en), .occ_rd_addr (occ_rd_addr), .occ_rd_data (occ_rd_data),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_hit (rsp_hit), .rsp_oob (rsp_oob),
    .rsp_color (rsp_color), .rsp_pos0 (rsp_pos0), .rsp_pos1 (rsp_pos1),
    .rsp_pos2 (rsp_pos2), .rsp_pos3 (rsp_pos3)
  );

  piece_probe #(.BOARD_W(12)) dut12 (
    .clk (clk), .rst (rst),
    .req_valid (req_valid12), .req_ready (req_ready12), .req_block (req_block),
    .req_status (req_status), .req_x (req_x), .req_y (req_y),
    .occ_rd_en (occ_rd_en12), .occ_rd_addr (occ_rd_addr12), .occ_rd_data (occ_rd_data12),
    .rsp_valid (rsp_valid12), .rsp_ready (rsp_ready12), .rsp_hit (rsp_hit12),
    .rsp_oob (rsp_oob12), .rsp_color (rsp_color12), .rsp_pos0 (rsp_pos0_12),
    .rsp_pos1 (rsp_pos1_12), .rsp_pos2 (rsp_pos2_12), .rsp_pos3 (rsp_pos3_12)
  );

  exp_t       sb[$];
  exp_t       sb12[$];
  logic [7:0] rd_log[$];
  logic [7:0] rd12_log[$];
  logic       mem [256];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         seen = 1'b0;

  function automatic exp_t mk(input logic hit, input logic oob, input logic [11:0] color,
                              input int p0, input int p1, input int p2, input int p3,
                              input logic [3:0] pmask, input int lat);
    exp_t e;
    e.hit   = hit;
    e.oob   = oob;
    e.color = color;
    e.pos   = {8'(p3), 8'(p2), 8'(p1), 8'(p0)};
    e.pmask = pmask;
    e.lat   = 8'(lat);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_rsp(input string tag, input exp_t e, input logic hit, input logic oob,
                         input logic [11:0] color, input logic [3:0][7:0] pos);
    chk({tag, "_hit"}, 32'(hit), 32'(e.hit));
    chk({tag, "_oob"}, 32'(oob), 32'(e.oob));
    chk({tag, "_color"}, 32'(color), 32'(e.color));
    for (int i = 0; i < 4; i++) begin
      if (e.pmask[i]) chk($sformatf("%s_pos%0d", tag, i), 32'(pos[i]), 32'(e.pos[i]));
    end
  endtask

  task automatic issue(input bit to12, input logic [2:0] b, input logic [1:0] s, input int x,
                       input int y, input exp_t e, input bit push);
    @(posedge clk); #1;
    req_block  = b;
    req_status = s;
    req_x      = 5'(x);
    req_y      = 5'(y);
    if (to12) req_valid12 = 1'b1;
    else      req_valid   = 1'b1;
    @(negedge clk);
    if (to12) chk("req_ready12", 32'(req_ready12), 1);
    else      chk("req_ready", 32'(req_ready), 1);
    if (push) begin
      if (to12) sb12.push_back(e);
      else begin
        sb.push_back(e);
        acc_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    req_valid   = 1'b0;
    req_valid12 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || sb12.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) chk("rsp_timeout", 32'(sb.size() + sb12.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Board RAM model for the 10-wide probe: data returned the cycle after the strobe.
  initial forever begin
    logic       en_s;
    logic [7:0] a_s;
    @(negedge clk);
    en_s = occ_rd_en;
    a_s  = occ_rd_addr;
    if (en_s) rd_log.push_back(a_s);
    @(posedge clk); #1;
    occ_rd_data = en_s ? mem[a_s] : 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (occ_rd_en12) rd12_log.push_back(occ_rd_addr12);
  end

  // Monitor for the 10-wide probe: checks every response cycle, pops on handshake.
  initial forever begin
    @(negedge clk);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
        end
        cmp_rsp("rsp", sb[0], rsp_hit, rsp_oob, rsp_color,
                {rsp_pos3, rsp_pos2, rsp_pos1, rsp_pos0});
        chk("req_ready_in_resp", 32'(req_ready), 0);
        if (rsp_ready) begin
          chk("read_count", 32'(rd_log.size()), sb[0].oob ? 0 : 4);
          if (!sb[0].oob && rd_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
              chk($sformatf("read_addr%0d", i), 32'(rd_log[i]), 32'(sb[0].pos[i]));
          end
          rd_log.delete();
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Monitor for the 12-wide probe.
  initial forever begin
    @(negedge clk);
    if (rsp_valid12) begin
      if (sb12.size() == 0) begin
        chk("unexpected_rsp12", 32'(rsp_valid12), 0);
      end else begin
        cmp_rsp("rsp12", sb12[0], rsp_hit12, rsp_oob12, rsp_color12,
                {rsp_pos3_12, rsp_pos2_12, rsp_pos1_12, rsp_pos0_12});
        chk("read_count12", 32'(rd12_log.size()), sb12[0].oob ? 0 : 4);
        if (!sb12[0].oob && rd12_log.size() == 4) begin
          for (int i = 0; i < 4; i++)
            chk($sformatf("read12_addr%0d", i), 32'(rd12_log[i]), 32'(sb12[0].pos[i]));
        end
        rd12_log.delete();
        void'(sb12.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_valid12 = 1'b0;
    req_block = '0; req_status = '0; req_x = '0; req_y = '0;
    rsp_ready = 1'b1; rsp_ready12 = 1'b1;
    occ_rd_data = 1'b0; occ_rd_data12 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_hit", 32'(rsp_hit), 0);
    chk("rst_rsp_oob", 32'(rsp_oob), 0);
    chk("rst_rsp_color", 32'(rsp_color), 0);
    chk("rst_pos", 32'({rsp_pos3, rsp_pos2, rsp_pos1, rsp_pos0}), 0);
    chk("rst_rd_en", 32'(occ_rd_en), 0);
    chk("rst_rd_addr", 32'(occ_rd_addr), 0);
    chk("rst_req_ready12", 32'(req_ready12), 1);

    // T status 0 at (4,0), empty board.
    issue(0, 3'd3, 2'd0, 4, 0, mk(0, 0, 12'hd7d, 4, 14, 3, 5, 4'hf, 7), 1);
    wait_idle();
    // Same piece with index 14 occupied.
    mem[14] = 1'b1;
    issue(0, 3'd3, 2'd0, 4, 0, mk(1, 0, 12'hd7d, 4, 14, 3, 5, 4'hf, 7), 1);
    wait_idle();
    mem[14] = 1'b0;
    // I status 0 at (8,5): right cell at x=10.
    issue(0, 3'd5, 2'd0, 8, 5, mk(0, 1, 12'h0ff, 58, 57, 59, 0, 4'b0111, 2), 1);
    wait_idle();
    // J status R at (4,0): bottom cell at y=-1.
    issue(0, 3'd0, 2'd1, 4, 0, mk(0, 1, 12'h22f, 4, 15, 14, 0, 4'b0111, 2), 1);
    wait_idle();
    // Illegal block code.
    issue(0, 3'd7, 2'd2, 3, 3, mk(0, 1, 12'h000, 0, 0, 0, 0, 4'hf, 2), 1);
    wait_idle();
    // S status 2 at (5,10): only the last-read cell is occupied.
    mem[94] = 1'b1;
    issue(0, 3'd2, 2'd2, 5, 10, mk(1, 0, 12'h0f0, 105, 106, 95, 94, 4'hf, 7), 1);
    wait_idle();

    // Z status L at (1,18) with the consumer stalling and a competing request.
    rsp_ready = 1'b0;
    issue(0, 3'd4, 2'd3, 1, 18, mk(0, 0, 12'hf00, 181, 170, 180, 191, 4'hf, 7), 1);
    begin
      int n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk("held_rsp_timeout", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1;
    req_block = 3'd3; req_status = 2'd0; req_x = 5'd2; req_y = 5'd2; req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    repeat (8) @(posedge clk);
    #1;

    // Reset during the second read cycle abandons the probe.
    issue(0, 3'd3, 2'd0, 4, 0, '0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rd_en_before_rst", 32'(occ_rd_en), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rd_en_after_rst", 32'(occ_rd_en), 0);
    chk("req_ready_after_rst", 32'(req_ready), 1);
    chk("rsp_valid_after_rst", 32'(rsp_valid), 0);
    repeat (12) @(posedge clk);
    #1;
    rd_log.delete();

    // L status 0 at (0,0): left cell off the board.
    issue(0, 3'd1, 2'd0, 0, 0, mk(0, 1, 12'hf80, 0, 11, 0, 1, 4'b1011, 2), 1);
    wait_idle();

    // 12-wide board: O at (10,3) fits, at (11,3) overhangs the right edge.
    issue(1, 3'd6, 2'd0, 10, 3, mk(0, 0, 12'hff0, 46, 58, 59, 47, 4'hf, 0), 1);
    wait_idle();
    issue(1, 3'd6, 2'd0, 11, 3, mk(0, 1, 12'hff0, 47, 59, 0, 0, 4'b0011, 0), 1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piece_probe.md
# piece_probe

Sequential placement checker for the tetromino playfield, parametrised on board size. It accepts a piece request (block code, rotation status, pivot x/y) and derives the four cell coordinates from the shared offset table. It bounds-checks them against the board, then reads the board occupancy RAM one cell per cycle and returns collision, out-of-bounds, colour and the four linear cell indices. It sits between the game controller (move/rotate/drop trial requests) and the board store, and replaces fixed 10-wide index arithmetic with a checked, handshaked probe.

## Interface
- `BOARD_W`, default 10: columns.
- `BOARD_H`, default 20: rows.
- `COORD_W`, default 5: unsigned width of request x/y; must hold max(`BOARD_W`, `BOARD_H`) - 1.
- `IDX_W`, default $clog2(`BOARD_W`*`BOARD_H`): linear index width, derived, not overridden.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_block`  in  3  piece code J=0, L=1, S=2, T=3, Z=4, I=5, O=6.
- `req_status`  in  2  rotation 0, R, 2, L = 0..3.
- `req_x`, `req_y`  in  COORD_W each  pivot column/row.
- `occ_rd_en`  out  1  occupancy read strobe.
- `occ_rd_addr`  out  IDX_W  index y*BOARD_W+x.
- `occ_rd_data`  in  1  occupied bit; valid the cycle after the strobe.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_hit`  out  1  at least one cell occupied.
- `rsp_oob`  out  1  any cell outside the board, or illegal block code.
- `rsp_color`  out  12  piece colour, RGB444.
- `rsp_pos0`..`rsp_pos3`  out  IDX_W each  cell indices; pos0 = pivot, pos1..3 in package table order.

## Operation
- States: IDLE, CALC, READ, DRAIN, RESP.
- IDLE: on `req_valid`, capture the request and go to CALC.
- CALC, 1 cycle:
  - Add the signed offsets (dx, dy in -2..+2) to the pivot at COORD_W+2 signed width.
  - A cell is oob if x<0, x>=BOARD_W, y<0 or y>=BOARD_H.
  - Register the indices and colour.
  - If oob, go to RESP with hit=0. Otherwise go to READ with counter k=0.
- READ, 4 cycles:
  - Issue `occ_rd_en`=1 with the address of cell k; k counts 0..3.
  - OR each returned `occ_rd_data` into hit.
  - All four reads are always issued; there is no early exit.
- DRAIN, 1 cycle: sample the data for cell 3, then go to RESP.
- RESP: hold `rsp_valid` and all rsp_* stable until `rsp_ready`, then go to IDLE.
- Illegal block code 7: oob=1, color=0, indices=0, no reads.
- When oob, `rsp_pos*` of out-of-range cells are don't-care; the other cells are valid.
- Reset values: state IDLE, `req_ready`=1 after reset deasserts, `rsp_valid`=0, `rsp_hit`=0, `rsp_oob`=0, `rsp_color`=0, `rsp_pos*`=0, `occ_rd_en`=0, `occ_rd_addr`=0.
- Reset mid-operation abandons the probe: no response, and `occ_rd_en` drops in the next cycle.

## Timing
- Request accepted at edge T (IDLE, `req_valid`=1).
- In-bounds: CALC in cycle T+1; reads in cycles T+2..T+5; DRAIN in T+6; `rsp_valid` high from T+7.
- Out-of-bounds: `rsp_valid` high from T+2, with zero reads.
- Response handshake completes at the edge where `rsp_valid` and `rsp_ready` are both high. The next request can be accepted no earlier than the following cycle, since IDLE is re-entered.
- There is no combinational path from `req_*` or `rsp_ready` to any output except through registers. `req_ready` is decoded from the state register.

## Structure
- `tetris_pkg` holds:
  - block codes, status codes, and COLOR_* constants;
  - the offset table: 7 blocks x 4 statuses x 4 cells of signed (dx, dy), with the pivot (0,0) first;
  - a function returning the colour for a block code.
- Sub-module `piece_offsets`: combinational block/status to four (dx, dy) plus a legal flag. It is shared with the renderer.
- `piece_probe` contains only the FSM, bounds logic, index multiply-add and read sequencing.

## Test plan
- Empty board, T status 0 at (4,0), 10x20:
  - `rsp_pos`=4,14,3,5, hit=0, oob=0, color=hd7d;
  - `rsp_valid` at T+7; four strobes at addresses 4,14,3,5.
- Same request with index 14 occupied -> hit=1, oob=0.
- I status 0 at (8,5) -> x+2=10, so oob=1, hit=0, `rsp_valid` at T+2, no `occ_rd_en` pulses. J status R at (4,0) -> y-1=-1, so oob=1.
- `rsp_ready` held low 5 cycles after `rsp_valid` -> all rsp_* stable, `req_ready`=0, a second `req_valid` is ignored until the handshake completes.
- `rst` pulsed during the second READ cycle -> no `rsp_valid`, `occ_rd_en`=0 the next cycle, `req_ready`=1 after release.
- `BOARD_W`=12: O status 0 at (10,3) -> indices 46,58,59,47, oob=0. At (11,3) -> oob=1.
